// File: rtl/johnson_phase_tracker_if.sv
// rtl/johnson_phase_tracker_if.sv - sample/result bundle between a Johnson counter tap and the phase tracker
interface johnson_phase_tracker_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    localparam int PW = $clog2(2 * N);

    logic             en;
    logic             clr;
    logic [N-1:0]     jc_q;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             locked;
    logic             step_err;
    logic             illegal;
    logic             rev_pulse;
    logic [CNT_W-1:0] rev_cnt;

    modport master (
        output en, clr, jc_q,
        input  phase, phase_valid, locked, step_err, illegal, rev_pulse, rev_cnt
    );

    modport slave (
        input  en, clr, jc_q,
        output phase, phase_valid, locked, step_err, illegal, rev_pulse, rev_cnt
    );
endinterface

// File: rtl/johnson_phase_tracker.sv
// rtl/johnson_phase_tracker.sv - decodes Johnson codes to phases, checks advance, counts revolutions
module johnson_phase_tracker #(
    parameter int N          = 4,
    parameter int CNT_W      = 8,
    parameter int LOCK_STEPS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    johnson_phase_tracker_if.slave bus
);
    localparam int P  = 2 * N;
    localparam int PW = $clog2(P);
    localparam int SW = $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {SEEK, TRACK, FAULT} state_t;

    state_t           state;
    logic [SW-1:0]    step_cnt;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             locked;
    logic             step_err;
    logic             illegal;
    logic             rev_pulse;
    logic [CNT_W-1:0] rev_cnt;

    logic             dec_legal;
    logic [PW-1:0]    dec_phase;
    logic [PW-1:0]    next_phase;
    logic [SW-1:0]    step_inc;

    // Code for phase k: k<=N fills ones from bit 0; beyond N the ones retreat toward the MSB.
    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] c;
        for (int i = 0; i < N; i++)
            c[i] = (k <= N) ? (i < k) : (i >= k - N);
        return c;
    endfunction

    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        for (int k = 0; k < P; k++) begin
            if (bus.jc_q == code_of(k)) begin
                dec_legal = 1'b1;
                dec_phase = PW'(k);
            end
        end
    end

    assign next_phase = (phase == PW'(P - 1)) ? '0 : phase + 1'b1;
    assign step_inc   = (step_cnt < SW'(LOCK_STEPS)) ? step_cnt + 1'b1 : step_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEEK;
            step_cnt    <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            step_err    <= 1'b0;
            illegal     <= 1'b0;
            rev_pulse   <= 1'b0;
            rev_cnt     <= '0;
        end else begin
            step_err  <= 1'b0;
            rev_pulse <= 1'b0;
            if (bus.clr) begin
                state       <= SEEK;
                step_cnt    <= '0;
                phase_valid <= 1'b0;
                locked      <= 1'b0;
                illegal     <= 1'b0;
                rev_cnt     <= '0;
            end else if (bus.en) begin
                case (state)
                    SEEK: begin
                        if (dec_legal) begin
                            phase       <= dec_phase;
                            phase_valid <= 1'b1;
                            step_cnt    <= '0;
                            state       <= TRACK;
                        end else begin
                            illegal     <= 1'b1;
                            phase_valid <= 1'b0;
                            locked      <= 1'b0;
                            state       <= FAULT;
                        end
                    end
                    TRACK: begin
                        if (!dec_legal) begin
                            illegal     <= 1'b1;
                            phase_valid <= 1'b0;
                            locked      <= 1'b0;
                            state       <= FAULT;
                        end else if (dec_phase == next_phase) begin
                            phase    <= dec_phase;
                            step_cnt <= step_inc;
                            if (step_inc == SW'(LOCK_STEPS))
                                locked <= 1'b1;
                            if (phase == PW'(P - 1)) begin
                                rev_pulse <= 1'b1;
                                rev_cnt   <= rev_cnt + 1'b1;
                            end
                        end else if (dec_phase != phase) begin
                            // Legal but out-of-order code: restart lock acquisition from here.
                            phase    <= dec_phase;
                            step_err <= 1'b1;
                            locked   <= 1'b0;
                            step_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.phase       = phase;
    assign bus.phase_valid = phase_valid;
    assign bus.locked      = locked;
    assign bus.step_err    = step_err;
    assign bus.illegal     = illegal;
    assign bus.rev_pulse   = rev_pulse;
    assign bus.rev_cnt     = rev_cnt;
endmodule
